// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and state encoding for the FIR feeder
package fir_pkg;
    localparam int TAPS       = 25;
    localparam int DW         = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PIPE_LAT   = 2;
    localparam int RUN_VALID  = TAPS + PIPE_LAT;
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: small circular sample buffer with flush, no pass-through when full
module fir_sample_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    // pointers wrap naturally at the power-of-two depth; flush discards everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset: reads are only used when the buffer is non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fir_feeder.sv
// fir_feeder: loads FIR coefficients, then streams buffered samples and tracks output validity
module fir_feeder
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_start,
    input  logic          coef_valid,
    input  logic [DW-1:0] coef_data,
    output logic          coef_ready,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          fir_reset,
    output logic          fir_load_c,
    output logic [DW-1:0] fir_coef,
    output logic [DW-1:0] fir_data,
    output logic          fir_out_valid,
    output logic          underflow,
    output logic          busy
);
    localparam int CW = $clog2(TAPS + 1);
    localparam int RW = $clog2(RUN_VALID + 1);
    state_t        state, state_nxt;
    logic [CW-1:0] coef_cnt;
    logic [RW-1:0] run_cnt;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_head;
    logic          coef_acc;
    assign coef_acc      = state == LOAD && coef_valid;
    assign s_ready       = !fifo_full && state != CLEAR;
    assign busy          = state == CLEAR || state == LOAD;
    assign fir_out_valid = state == RUN && run_cnt == RW'(RUN_VALID);

    fir_sample_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid && s_ready),
        .flush (state == CLEAR),
        .din   (s_data),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    // next state and the combinational drive into the FIR input registers
    always_comb begin
        state_nxt  = state;
        fir_reset  = 1'b0;
        coef_ready = 1'b0;
        fir_load_c = 1'b0;
        fir_coef   = '0;
        fir_data   = '0;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                fir_reset = 1'b1;
                if (cfg_start) state_nxt = CLEAR;
            end
            CLEAR: begin
                fir_reset = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                coef_ready = 1'b1;
                fir_load_c = coef_valid;
                fir_coef   = coef_valid ? coef_data : '0;
                if (coef_valid && coef_cnt == CW'(TAPS - 1)) state_nxt = RUN;
            end
            RUN: begin
                fifo_pop = !fifo_empty;
                fir_data = fifo_empty ? '0 : fifo_head;
                if (cfg_start) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // number of coefficients shifted into the FIR during this load sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) coef_cnt <= '0;
        else if (state == CLEAR) coef_cnt <= '0;
        else if (coef_acc) coef_cnt <= coef_cnt + CW'(1);
    end

    // RUN cycle index including the current cycle, saturating once the window is full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_cnt <= '0;
        else if (state_nxt != RUN) run_cnt <= '0;
        else if (state != RUN) run_cnt <= RW'(1);
        else if (run_cnt != RW'(RUN_VALID)) run_cnt <= run_cnt + RW'(1);
    end

    // sticky starvation flag, cleared only by a new configuration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) underflow <= 1'b0;
        else if (state == CLEAR) underflow <= 1'b0;
        else if (state == RUN && fifo_empty) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: directed sequence with random data against a queue-based behavioural model
module tb_fir_feeder;
    import fir_pkg::*;
    localparam int MI = 0, MC = 1, ML = 2, MR = 3;
    logic          clk = 1'b0;
    logic          reset, cfg_start, coef_valid, s_valid;
    logic [DW-1:0] coef_data, s_data;
    logic          coef_ready, s_ready, fir_reset, fir_load_c, fir_out_valid, underflow, busy;
    logic [DW-1:0] fir_coef, fir_data;
    int            checks = 0, failures = 0;
    int            loads, mode, ncoef, run_n, sp;
    bit            m_uf;
    logic [DW-1:0] q[$], prime[$];

    always #5 clk = ~clk;

    fir_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .coef_valid    (coef_valid),
        .coef_data     (coef_data),
        .coef_ready    (coef_ready),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .fir_reset     (fir_reset),
        .fir_load_c    (fir_load_c),
        .fir_coef      (fir_coef),
        .fir_data      (fir_data),
        .fir_out_valid (fir_out_valid),
        .underflow     (underflow),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = MI;
        q.delete();
        m_uf = 1'b0;
        run_n = 0;
        ncoef = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_coef_ready", coef_ready, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_fir_reset", fir_reset, 1);
        chk("rst_fir_load_c", fir_load_c, 0);
        chk("rst_fir_coef", fir_coef, 0);
        chk("rst_fir_data", fir_data, 0);
        chk("rst_fir_out_valid", fir_out_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_busy", busy, 0);
    endtask

    // one clock: drive samples per policy, compare every output with the model, advance the model
    task automatic cycle();
        bit acc, push;
        logic [DW-1:0] ed;
        case (sp)
            1: begin s_valid = 1'b1; s_data = DW'($urandom); end
            2: begin s_valid = 1'($urandom_range(0, 1)); s_data = DW'($urandom); end
            3: begin s_valid = prime.size() > 0; s_data = prime.size() > 0 ? prime[0] : '0; end
            default: s_valid = 1'b0;
        endcase
        #1;
        acc = mode == ML && coef_valid;
        ed  = (mode == MR && q.size() > 0) ? q[0] : '0;
        chk("fir_reset", fir_reset, mode == MI || mode == MC);
        chk("busy", busy, mode == MC || mode == ML);
        chk("coef_ready", coef_ready, mode == ML);
        chk("fir_load_c", fir_load_c, acc);
        chk("fir_coef", fir_coef, acc ? coef_data : '0);
        chk("fir_data", fir_data, ed);
        chk("s_ready", s_ready, q.size() < FIFO_DEPTH && mode != MC);
        chk("fir_out_valid", fir_out_valid, mode == MR && run_n >= RUN_VALID);
        chk("underflow", underflow, m_uf);
        loads += int'(fir_load_c);
        push = s_valid && q.size() < FIFO_DEPTH && mode != MC;
        if (sp == 3 && push) void'(prime.pop_front());
        case (mode)
            MI: if (cfg_start) mode = MC;
            MC: begin q.delete(); m_uf = 1'b0; ncoef = 0; mode = ML; end
            ML: if (acc) begin
                ncoef++;
                if (ncoef == TAPS) begin mode = MR; run_n = 1; end
            end
            default: begin
                if (q.size() > 0) void'(q.pop_front());
                else m_uf = 1'b1;
                run_n++;
                if (cfg_start) mode = MC;
            end
        endcase
        if (push) q.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg();
        cfg_start = 1'b1;
        cycle();
        #1;
        chk("clear_fir_reset", fir_reset, 1);
        chk("clear_busy", busy, 1);
        chk("clear_out_valid", fir_out_valid, 0);
        cfg_start = 1'b0;
        cycle();
    endtask

    task automatic feed(input int n, input int gap_at, input int gap_len, input bit seq);
        int g = 0;
        int i = 0;
        loads = 0;
        while (i < n) begin
            if (i == gap_at && g < gap_len) begin
                coef_valid = 1'b0;
                g++;
            end else begin
                coef_valid = 1'b1;
                coef_data  = seq ? DW'(i + 1) : DW'($urandom);
                i++;
            end
            cycle();
        end
        coef_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] t3d [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00};
        bit            t3u [6] = '{0, 0, 0, 0, 0, 1};
        reset = 1'b1; cfg_start = 1'b0; coef_valid = 1'b0; coef_data = '0;
        s_valid = 1'b0; s_data = '0; sp = 0; loads = 0;
        model_reset();
        #3 reset = 1'b0;
        #1 chk_reset_vals();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) cycle();
        // back-to-back coefficients 1..25
        cfg();
        feed(TAPS, -1, 0, 1'b1);
        #1;
        chk("t1_loads", loads, TAPS);
        chk("t1_run_busy", busy, 0);
        chk("t1_run_coef_ready", coef_ready, 0);
        repeat (3) cycle();
        // gapped load with four primed samples
        cfg();
        prime = '{8'h11, 8'h12, 8'h13, 8'h14};
        sp = 3;
        feed(TAPS, 10, 3, 1'b0);
        sp = 0;
        #1;
        chk("t2_loads", loads, TAPS);
        chk("t3_full", s_ready, 0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_data", fir_data, t3d[k]);
            chk("t3_underflow", underflow, t3u[k]);
            cycle();
        end
        // continuous streaming until the window fills
        sp = 1;
        cfg();
        feed(TAPS, -1, 0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            #1;
            if (k == RUN_VALID - 1) chk("t4_valid_early", fir_out_valid, 0);
            if (k == RUN_VALID) chk("t4_valid_on", fir_out_valid, 1);
            cycle();
        end
        #1 chk("t4_underflow", underflow, 0);
        // restart from RUN with two samples queued
        sp = 0;
        for (int k = 0; k < 8 && q.size() > 2; k++) cycle();
        cfg_start = 1'b1;
        cycle();
        #1;
        chk("t5_clear_valid", fir_out_valid, 0);
        chk("t5_clear_busy", busy, 1);
        cfg_start = 1'b0;
        cycle();
        #1;
        chk("t5_underflow_cleared", underflow, 0);
        chk("t5_fifo_empty", s_ready, 1);
        feed(TAPS, -1, 0, 1'b0);
        #1;
        chk("t5_loads", loads, TAPS);
        chk("t5_empty_data", fir_data, 0);
        cycle();
        #1 chk("t5_underflow", underflow, 1);
        // asynchronous reset in the middle of a load
        sp = 2;
        cfg();
        feed(12, -1, 0, 1'b0);
        s_valid = 1'b0;
        coef_valid = 1'b1;
        coef_data = 8'hAA;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_reset_vals();
        #2 reset = 1'b1;
        coef_valid = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        cfg();
        feed(TAPS, -1, 0, 1'b0);
        #1 chk("t6_loads", loads, TAPS);
        repeat (10) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
